pwm_tone_sequencer: RTL and testbench

//  Sequences the sine-PWM generator through a programmable list of tones.

---
 rtl/pwm_tone_sequencer.sv | 179 +++++++++++++++++
 tb/tb_pwm_tone_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_tone_sequencer.sv
// Steps the sine-PWM generator through a small table of (N, duration) tones,
// gating its output per entry with optional inter-note gaps and looping.
module pwm_tone_sequencer #(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int DUR_W     = 16,
    parameter int TICK_DIV  = 50000,
    parameter int GAP_TICKS = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [11:0]      wr_n,
    input  logic [DUR_W-1:0] wr_dur,
    input  logic [AW:0]      length,
    input  logic             loop,
    input  logic             start,
    input  logic             stop,
    output logic [11:0]      N_out,
    output logic             pwm_en,
    output logic [AW-1:0]    note_idx,
    output logic             busy,
    output logic             done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DUR_W-1:0] GAP_LAST   = DUR_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    typedef enum logic [2:0] {IDLE, LOAD, NOTE, GAP, FIN} state_t;

    state_t state, state_nx, adv_state;

    logic [11:0]      table_n   [DEPTH];
    logic [DUR_W-1:0] table_dur [DEPTH];

    logic [AW-1:0]    idx, idx_nx, adv_idx;
    logic [AW:0]      len_r;
    logic             loop_r;
    logic [DUR_W-1:0] dur_r;
    logic [PW-1:0]    presc;
    logic [DUR_W-1:0] tick_cnt;

    logic             tick, note_end, gap_end, last_entry;
    logic [11:0]      cur_n;
    logic [DUR_W-1:0] cur_dur;

    // Table storage has no reset so a programmed song survives a reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            table_n[wr_addr]   <= wr_n;
            table_dur[wr_addr] <= wr_dur;
        end
    end

    assign cur_n      = table_n[idx];
    assign cur_dur    = table_dur[idx];
    assign tick       = (presc == PRESC_LAST);
    assign note_end   = tick && (tick_cnt == dur_r - DUR_W'(1));
    assign gap_end    = tick && (tick_cnt == GAP_LAST);
    assign last_entry = ({1'b0, idx} == len_r - (AW+1)'(1));
    assign busy       = (state != IDLE);

    always_comb begin
        adv_state = LOAD;
        adv_idx   = idx + AW'(1);
        if (last_entry) begin
            adv_idx   = '0;
            adv_state = loop_r ? LOAD : FIN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    idx_nx   = '0;
                    state_nx = (length == '0) ? FIN : LOAD;
                end
            end
            LOAD: begin
                if (cur_dur == '0) begin
                    state_nx = adv_state;
                    idx_nx   = adv_idx;
                end else begin
                    state_nx = NOTE;
                end
            end
            NOTE: begin
                if (note_end) begin
                    if (GAP_TICKS > 0) begin
                        state_nx = GAP;
                    end else begin
                        state_nx = adv_state;
                        idx_nx   = adv_idx;
                    end
                end
            end
            GAP: begin
                if (gap_end) begin
                    state_nx = adv_state;
                    idx_nx   = adv_idx;
                end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (stop && state != IDLE) begin
            state_nx = IDLE;
        end
    end

    // Skipped (zero-duration) entries never reach N_out, so the generator
    // keeps seeing the last tone that actually played.
    always_ff @(posedge clk) begin
        if (rst) begin
            N_out    <= '0;
            pwm_en   <= 1'b0;
            note_idx <= '0;
            done     <= 1'b0;
            presc    <= '0;
            tick_cnt <= '0;
            dur_r    <= '0;
            len_r    <= '0;
            loop_r   <= 1'b0;
        end else begin
            done <= (state == FIN) && !stop;
            if (state == IDLE && start && !stop) begin
                len_r  <= length;
                loop_r <= loop;
            end
            case (state)
                LOAD: begin
                    presc    <= '0;
                    tick_cnt <= '0;
                    note_idx <= idx;
                    dur_r    <= cur_dur;
                    if (cur_dur != '0) begin
                        N_out  <= cur_n;
                        pwm_en <= (cur_n != 12'd0);
                    end else begin
                        pwm_en <= 1'b0;
                    end
                end
                NOTE, GAP: begin
                    if (tick) begin
                        presc    <= '0;
                        tick_cnt <= tick_cnt + DUR_W'(1);
                    end else begin
                        presc <= presc + PW'(1);
                    end
                    if (state == NOTE && note_end) begin
                        pwm_en   <= 1'b0;
                        presc    <= '0;
                        tick_cnt <= '0;
                    end
                end
                default: ;
            endcase
            if (stop && state != IDLE) begin
                pwm_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_tone_sequencer.sv
// Self-checking bench for pwm_tone_sequencer: a per-cycle expected trace is
// queued at each start and a monitor compares it against the outputs.
module tb_pwm_tone_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en_a, wr_en_g;
    logic [3:0]  wr_addr;
    logic [11:0] wr_n;
    logic [15:0] wr_dur;
    logic [4:0]  length;
    logic        loop;
    logic        start_a, start_g;
    logic        stop;

    logic [11:0] n_a, n_g;
    logic        pwm_a, pwm_g, busy_a, busy_g, done_a, done_g;
    logic [3:0]  idx_a, idx_g;

    logic        use_gap;
    logic [11:0] obs_n;
    logic        obs_pwm, obs_busy, obs_done;
    logic [3:0]  obs_idx;

    typedef struct {
        logic        pwm;
        logic [11:0] n;
        logic        busy;
        logic        done;
        logic        chk_idx;
        logic [3:0]  idx;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [11:0] model_n;
    logic [11:0] tn [16];
    logic [15:0] td [16];

    always #5 clk = ~clk;

    pwm_tone_sequencer #(.DEPTH(16), .AW(4), .DUR_W(16), .TICK_DIV(4), .GAP_TICKS(0)) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en_a), .wr_addr(wr_addr), .wr_n(wr_n), .wr_dur(wr_dur),
        .length(length), .loop(loop), .start(start_a), .stop(stop),
        .N_out(n_a), .pwm_en(pwm_a), .note_idx(idx_a), .busy(busy_a), .done(done_a));

    pwm_tone_sequencer #(.DEPTH(16), .AW(4), .DUR_W(16), .TICK_DIV(4), .GAP_TICKS(1)) dut_g (
        .clk(clk), .rst(rst), .wr_en(wr_en_g), .wr_addr(wr_addr), .wr_n(wr_n), .wr_dur(wr_dur),
        .length(length), .loop(loop), .start(start_g), .stop(stop),
        .N_out(n_g), .pwm_en(pwm_g), .note_idx(idx_g), .busy(busy_g), .done(done_g));

    assign obs_n    = use_gap ? n_g    : n_a;
    assign obs_pwm  = use_gap ? pwm_g  : pwm_a;
    assign obs_busy = use_gap ? busy_g : busy_a;
    assign obs_done = use_gap ? done_g : done_a;
    assign obs_idx  = use_gap ? idx_g  : idx_a;

    // Scoreboard monitor: one expected entry per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            cyc++;
            tests += 4;
            if (obs_pwm !== mon_e.pwm) begin
                fails++;
                $display("[TB] FAIL sb_pwm_en cyc %0d: got %0b expected %0b", cyc, obs_pwm, mon_e.pwm);
            end
            if (obs_n !== mon_e.n) begin
                fails++;
                $display("[TB] FAIL sb_N_out cyc %0d: got %0d expected %0d", cyc, obs_n, mon_e.n);
            end
            if (obs_busy !== mon_e.busy) begin
                fails++;
                $display("[TB] FAIL sb_busy cyc %0d: got %0b expected %0b", cyc, obs_busy, mon_e.busy);
            end
            if (obs_done !== mon_e.done) begin
                fails++;
                $display("[TB] FAIL sb_done cyc %0d: got %0b expected %0b", cyc, obs_done, mon_e.done);
            end
            if (mon_e.chk_idx) begin
                tests++;
                if (obs_idx !== mon_e.idx) begin
                    fails++;
                    $display("[TB] FAIL sb_note_idx cyc %0d: got %0d expected %0d", cyc, obs_idx, mon_e.idx);
                end
            end
        end
    end

    task automatic push(input logic pwm, input logic bsy, input logic dn, input logic chk, input logic [3:0] ix);
        exp_t e;
        e.pwm = pwm; e.n = model_n; e.busy = bsy; e.done = dn; e.chk_idx = chk; e.idx = ix;
        sb.push_back(e);
    endtask

    task automatic push_pass(input int len, input int gap);
        for (int i = 0; i < len; i++) begin
            push(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
            if (td[i] != 16'd0) begin
                model_n = tn[i];
                for (int c = 0; c < int'(td[i]) * 4; c++) push(tn[i] != 12'd0, 1'b1, 1'b0, 1'b1, 4'(i));
                for (int c = 0; c < gap * 4; c++) push(1'b0, 1'b1, 1'b0, 1'b1, 4'(i));
            end
        end
    endtask

    task automatic push_finish();
        push(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        push(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        push(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic write_entry(input logic g, input int addr, input logic [11:0] n, input logic [15:0] dur);
        @(negedge clk);
        wr_addr = 4'(addr); wr_n = n; wr_dur = dur;
        wr_en_a = !g; wr_en_g = g;
        tn[addr] = n; td[addr] = dur;
        @(posedge clk); #1;
        wr_en_a = 1'b0; wr_en_g = 1'b0;
    endtask

    task automatic kick(input logic [4:0] len, input logic lp);
        @(negedge clk);
        length = len; loop = lp;
        start_a = !use_gap; start_g = use_gap;
        @(posedge clk); #1;
        start_a = 1'b0; start_g = 1'b0;
    endtask

    task automatic drain(input string name);
        int b = 600;
        while (sb.size() != 0 && b > 0) begin
            @(negedge clk);
            b--;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("[TB] FAIL %s_drain: %0d entries left, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        write_entry(1'b0, 0, 12'd100, 16'd2);
        write_entry(1'b0, 1, 12'd200, 16'd1);
        kick(5'd2, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        tests += 2;
        if (pwm_a !== 1'b1) begin fails++; $display("[TB] FAIL reset_pre_pwm: got %0b expected 1", pwm_a); end
        if (n_a !== 12'd100) begin fails++; $display("[TB] FAIL reset_pre_n: got %0d expected 100", n_a); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests += 5;
        if (pwm_a !== 1'b0) begin fails++; $display("[TB] FAIL reset_pwm: got %0b expected 0", pwm_a); end
        if (n_a !== 12'd0) begin fails++; $display("[TB] FAIL reset_n: got %0d expected 0", n_a); end
        if (busy_a !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy_a); end
        if (done_a !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %0b expected 0", done_a); end
        if (idx_a !== 4'd0) begin fails++; $display("[TB] FAIL reset_idx: got %0d expected 0", idx_a); end
        model_n = 12'd0;
    endtask

    // Plays the table written before reset, so it also proves retention.
    task automatic test_single_pass();
        kick(5'd2, 1'b0);
        push_pass(2, 0);
        push_finish();
        drain("single_pass");
    endtask

    task automatic test_loop();
        kick(5'd2, 1'b1);
        push_pass(2, 0);
        push_pass(2, 0);
        push(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        model_n = tn[0];
        for (int c = 0; c < 6; c++) push(1'b1, 1'b1, 1'b0, 1'b1, 4'd0);
        drain("loop");
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        for (int c = 0; c < 4; c++) push(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        drain("loop_stop");
    endtask

    task automatic test_rest_skip();
        write_entry(1'b0, 0, 12'd0, 16'd3);
        write_entry(1'b0, 1, 12'd50, 16'd0);
        write_entry(1'b0, 2, 12'd70, 16'd1);
        kick(5'd3, 1'b0);
        push_pass(3, 0);
        push_finish();
        drain("rest_skip");
    endtask

    task automatic test_zero_length();
        kick(5'd0, 1'b0);
        push(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        push(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        push(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        drain("zero_length");
        @(negedge clk);
        length = 5'd2; start_a = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; stop = 1'b0;
        for (int c = 0; c < 3; c++) push(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        drain("start_stop");
    endtask

    task automatic test_full_length();
        for (int i = 0; i < 16; i++)
            write_entry(1'b0, i, 12'(i * 16 + 5), (i % 4 == 3) ? 16'd0 : 16'd1);
        kick(5'd16, 1'b0);
        push_pass(16, 0);
        push_finish();
        drain("full_length");
    endtask

    task automatic test_gap();
        use_gap = 1'b1;
        model_n = 12'd0;
        write_entry(1'b1, 0, 12'd300, 16'd1);
        write_entry(1'b1, 1, 12'd400, 16'd1);
        kick(5'd2, 1'b0);
        push_pass(2, 1);
        push_finish();
        drain("gap");
        use_gap = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en_a = 1'b0; wr_en_g = 1'b0; wr_addr = '0; wr_n = '0; wr_dur = '0;
        length = '0; loop = 1'b0; start_a = 1'b0; start_g = 1'b0; stop = 1'b0;
        use_gap = 1'b0; model_n = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_single_pass();
        test_loop();
        test_rest_skip();
        test_zero_length();
        test_full_length();
        test_gap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
